// File: rtl/ip_tx_builder.sv
// IPv4 transmit header builder: prepends a 20-byte header with computed checksum
// and realigns the 64-bit payload by 4 bytes behind it.
module ip_tx_builder #(
    parameter logic [7:0] P_TTL = 8'd64,
    parameter logic [7:0] P_TOS = 8'd0
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_src_ip,
    input  logic [31:0] i_dst_ip,
    input  logic [63:0] s_axis_ip_data,
    input  logic [55:0] s_axis_ip_user,
    input  logic [7:0]  s_axis_ip_keep,
    input  logic        s_axis_ip_last,
    input  logic        s_axis_ip_valid,
    output logic        s_axis_ip_ready,
    output logic [63:0] m_axis_mac_data,
    output logic [47:0] m_axis_mac_user,
    output logic [7:0]  m_axis_mac_keep,
    output logic        m_axis_mac_last,
    output logic        m_axis_mac_valid,
    input  logic        m_axis_mac_ready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CSUM1,
        S_CSUM2,
        S_HDR0,
        S_HDR1,
        S_DATA,
        S_TAIL
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] total_len_q, total_len_d;
    logic [15:0] id_q, id_d;
    logic [2:0]  flags_q, flags_d;
    logic [12:0] offset_q, offset_d;
    logic [7:0]  proto_q, proto_d;
    logic [31:0] src_q, src_d;
    logic [31:0] dst_q, dst_d;
    logic [19:0] sum_q, sum_d;
    logic [15:0] csum_q, csum_d;
    logic [31:0] residue_q, residue_d;
    logic [3:0]  keep_saved_q, keep_saved_d;
    logic [63:0] data_q, data_d;
    logic [47:0] user_q, user_d;
    logic [7:0]  keep_q, keep_d;
    logic        last_q, last_d;
    logic        valid_q, valid_d;

    logic        ld;
    logic        s_ready;
    logic [15:0] hdr_words [9];
    logic [19:0] sum_c;
    logic [16:0] fold1;
    logic [16:0] fold2;
    logic [3:0]  in_cnt;

    function automatic logic [3:0] popcount8(input logic [7:0] k);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'b000, k[i]};
        end
        return c;
    endfunction

    assign ld      = !valid_q || m_axis_mac_ready;
    assign s_ready = (state_q == S_DATA) && ld;
    assign in_cnt  = popcount8(s_axis_ip_keep);

    // Header words with the checksum field taken as zero
    assign hdr_words[0] = {4'h4, 4'h5, P_TOS};
    assign hdr_words[1] = total_len_q;
    assign hdr_words[2] = id_q;
    assign hdr_words[3] = {flags_q, offset_q};
    assign hdr_words[4] = {P_TTL, proto_q};
    assign hdr_words[5] = src_q[31:16];
    assign hdr_words[6] = src_q[15:0];
    assign hdr_words[7] = dst_q[31:16];
    assign hdr_words[8] = dst_q[15:0];

    always_comb begin
        sum_c = 20'd0;
        for (int i = 0; i < 9; i++) begin
            sum_c = sum_c + {4'h0, hdr_words[i]};
        end
    end

    assign fold1 = {1'b0, sum_q[15:0]} + {13'h0, sum_q[19:16]};
    assign fold2 = {1'b0, fold1[15:0]} + {16'h0, fold1[16]};

    always_comb begin
        state_d      = state_q;
        total_len_d  = total_len_q;
        id_d         = id_q;
        flags_d      = flags_q;
        offset_d     = offset_q;
        proto_d      = proto_q;
        src_d        = src_q;
        dst_d        = dst_q;
        sum_d        = sum_q;
        csum_d       = csum_q;
        residue_d    = residue_q;
        keep_saved_d = keep_saved_q;
        data_d       = data_q;
        user_d       = user_q;
        keep_d       = keep_q;
        last_d       = last_q;
        valid_d      = valid_q;

        // An output slot that is free or being drained empties unless a state fills it
        if (ld) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (s_axis_ip_valid) begin
                    total_len_d = s_axis_ip_user[55:40] + 16'd20;
                    flags_d     = s_axis_ip_user[39:37];
                    proto_d     = s_axis_ip_user[36:29];
                    offset_d    = s_axis_ip_user[28:16];
                    id_d        = s_axis_ip_user[15:0];
                    src_d       = i_src_ip;
                    dst_d       = i_dst_ip;
                    state_d     = S_CSUM1;
                end
            end
            S_CSUM1: begin
                sum_d   = sum_c;
                state_d = S_CSUM2;
            end
            S_CSUM2: begin
                csum_d  = ~fold2[15:0];
                state_d = S_HDR0;
            end
            S_HDR0: begin
                if (ld) begin
                    data_d  = {8'h45, P_TOS, total_len_q, id_q, flags_q, offset_q};
                    keep_d  = 8'hFF;
                    valid_d = 1'b1;
                    user_d  = {total_len_q, dst_q};
                    state_d = S_HDR1;
                end
            end
            S_HDR1: begin
                if (ld) begin
                    data_d    = {P_TTL, proto_q, csum_q, src_q};
                    keep_d    = 8'hFF;
                    valid_d   = 1'b1;
                    residue_d = dst_q;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                if (s_axis_ip_valid && s_ready) begin
                    data_d    = {residue_q, s_axis_ip_data[63:32]};
                    residue_d = s_axis_ip_data[31:0];
                    valid_d   = 1'b1;
                    keep_d    = 8'hFF;
                    if (s_axis_ip_last) begin
                        if (in_cnt <= 4'd4) begin
                            keep_d  = {4'hF, s_axis_ip_keep[7:4]};
                            last_d  = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            keep_saved_d = s_axis_ip_keep[3:0];
                            state_d      = S_TAIL;
                        end
                    end
                end
            end
            S_TAIL: begin
                if (ld) begin
                    data_d  = {residue_q, 32'h0};
                    keep_d  = {keep_saved_q, 4'h0};
                    last_d  = 1'b1;
                    valid_d = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= S_IDLE;
            total_len_q  <= '0;
            id_q         <= '0;
            flags_q      <= '0;
            offset_q     <= '0;
            proto_q      <= '0;
            src_q        <= '0;
            dst_q        <= '0;
            sum_q        <= '0;
            csum_q       <= '0;
            residue_q    <= '0;
            keep_saved_q <= '0;
            data_q       <= '0;
            user_q       <= '0;
            keep_q       <= '0;
            last_q       <= 1'b0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            total_len_q  <= total_len_d;
            id_q         <= id_d;
            flags_q      <= flags_d;
            offset_q     <= offset_d;
            proto_q      <= proto_d;
            src_q        <= src_d;
            dst_q        <= dst_d;
            sum_q        <= sum_d;
            csum_q       <= csum_d;
            residue_q    <= residue_d;
            keep_saved_q <= keep_saved_d;
            data_q       <= data_d;
            user_q       <= user_d;
            keep_q       <= keep_d;
            last_q       <= last_d;
            valid_q      <= valid_d;
        end
    end

    assign s_axis_ip_ready  = s_ready;
    assign m_axis_mac_data  = data_q;
    assign m_axis_mac_user  = user_q;
    assign m_axis_mac_keep  = keep_q;
    assign m_axis_mac_last  = last_q;
    assign m_axis_mac_valid = valid_q;

endmodule

// File: tb/tb_ip_tx_builder.sv
// Scoreboard bench for ip_tx_builder: a byte-level reference model predicts every
// output beat, the monitor pops and compares on each downstream handshake.
module tb_ip_tx_builder;

    localparam logic [7:0] TTL = 8'd64;
    localparam logic [7:0] TOS = 8'd0;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic [47:0] user;
    } beat_t;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic [31:0] i_src_ip = '0;
    logic [31:0] i_dst_ip = '0;
    logic [63:0] s_data = '0;
    logic [55:0] s_user = '0;
    logic [7:0]  s_keep = '0;
    logic        s_last = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [63:0] m_data;
    logic [47:0] m_user;
    logic [7:0]  m_keep;
    logic        m_last;
    logic        m_valid;
    logic        m_ready = 1'b1;

    int    n_checks = 0;
    int    n_errors = 0;
    int    cyc = 0;
    int    first_valid_cyc = -1;
    bit    stall_en = 1'b0;
    beat_t exp_q[$];
    beat_t obs_q[$];
    logic [63:0] pkt_q[$];

    ip_tx_builder #(.P_TTL(TTL), .P_TOS(TOS)) dut (
        .i_clk            (i_clk),
        .i_rst_n          (i_rst_n),
        .i_src_ip         (i_src_ip),
        .i_dst_ip         (i_dst_ip),
        .s_axis_ip_data   (s_data),
        .s_axis_ip_user   (s_user),
        .s_axis_ip_keep   (s_keep),
        .s_axis_ip_last   (s_last),
        .s_axis_ip_valid  (s_valid),
        .s_axis_ip_ready  (s_ready),
        .m_axis_mac_data  (m_data),
        .m_axis_mac_user  (m_user),
        .m_axis_mac_keep  (m_keep),
        .m_axis_mac_last  (m_last),
        .m_axis_mac_valid (m_valid),
        .m_axis_mac_ready (m_ready)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc++;

    always @(posedge i_clk) begin
        #1;
        m_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] keep_mask(input logic [7:0] k);
        logic [63:0] m;
        m = '0;
        for (int j = 0; j < 8; j++) m[63-8*j -: 8] = {8{k[7-j]}};
        return m;
    endfunction

    // Reference model: serialise header + payload bytes, then cut into 8-byte beats
    task automatic push_expected(input logic [15:0] len, input logic [2:0] flags,
                                 input logic [7:0] proto, input logic [12:0] off,
                                 input logic [15:0] id, input logic [31:0] src,
                                 input logic [31:0] dst, input int nb, input logic [7:0] lkeep);
        logic [7:0]  by[$];
        logic [15:0] tl;
        logic [15:0] fo;
        logic [7:0]  kk;
        int unsigned s;
        int          n;
        int          rem;
        beat_t       e;
        tl = len + 16'd20;
        fo = {flags, off};
        by = '{8'h45, TOS, tl[15:8], tl[7:0], id[15:8], id[7:0], fo[15:8], fo[7:0],
               TTL, proto, 8'h00, 8'h00, src[31:24], src[23:16], src[15:8], src[7:0],
               dst[31:24], dst[23:16], dst[15:8], dst[7:0]};
        s = 0;
        for (int i = 0; i < 10; i++) s += {16'h0, by[2*i], by[2*i+1]};
        while ((s >> 16) != 0) s = (s & 32'hFFFF) + (s >> 16);
        by[10] = ~s[15:8];
        by[11] = ~s[7:0];
        for (int b = 0; b < nb; b++) begin
            n = (b == nb - 1) ? $countones(lkeep) : 8;
            for (int j = 0; j < n; j++) by.push_back(pkt_q[b][63-8*j -: 8]);
        end
        for (int o = 0; o < by.size(); o += 8) begin
            rem = by.size() - o;
            if (rem > 8) rem = 8;
            e.data = '0;
            for (int j = 0; j < rem; j++) e.data[63-8*j -: 8] = by[o+j];
            kk = 8'hFF >> rem;
            e.keep = ~kk;
            e.last = (o + 8 >= by.size());
            e.user = {tl, dst};
            exp_q.push_back(e);
        end
    endtask

    // Entered just after a rising edge; returns just after a rising edge
    task automatic send_pkt(input logic [15:0] len, input logic [2:0] flags,
                            input logic [7:0] proto, input logic [12:0] off,
                            input logic [15:0] id, input logic [31:0] src,
                            input logic [31:0] dst, input logic [7:0] lkeep, input int rst_after);
        int  nb;
        bit  acc;
        nb = pkt_q.size();
        push_expected(len, flags, proto, off, id, src, dst, nb, lkeep);
        i_src_ip = src;
        i_dst_ip = dst;
        s_user   = {len, flags, proto, off, id};
        for (int b = 0; b < nb; b++) begin
            s_valid = 1'b1;
            s_data  = pkt_q[b];
            s_last  = (b == nb - 1);
            s_keep  = (b == nb - 1) ? lkeep : 8'hFF;
            acc = 1'b0;
            for (int t = 0; t < 300 && !acc; t++) begin
                @(negedge i_clk);
                if (s_ready) acc = 1'b1;
            end
            if (!acc) begin
                check("s_ready_timeout", 64'(acc), 64'd1);
                s_valid = 1'b0;
                return;
            end
            @(posedge i_clk);
            #1;
            if (rst_after == b) begin
                i_rst_n = 1'b0;
                #1;
                check("rst_data", m_data, 64'd0);
                check("rst_user", 64'(m_user), 64'd0);
                check("rst_keep", 64'(m_keep), 64'd0);
                check("rst_last", 64'(m_last), 64'd0);
                check("rst_valid", 64'(m_valid), 64'd0);
                check("rst_sready", 64'(s_ready), 64'd0);
                s_valid = 1'b0;
                return;
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 400 && exp_q.size() != 0; t++) @(negedge i_clk);
        if (exp_q.size() != 0) check("drain_timeout", 64'(exp_q.size()), 64'd0);
        @(posedge i_clk);
        #1;
    endtask

    task automatic fill_pkt(input int nb, input logic [63:0] beat0);
        pkt_q.delete();
        for (int b = 0; b < nb; b++) pkt_q.push_back(b == 0 ? beat0 : {$urandom, $urandom});
    endtask

    // Monitor: handshake outputs seen at the falling edge complete at the next rising edge
    logic        prev_stall = 1'b0;
    logic [63:0] prev_data;
    logic [7:0]  prev_keep;
    logic        prev_last;
    always @(negedge i_clk) begin
        beat_t e;
        beat_t o;
        logic [63:0] mk;
        if (!i_rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (prev_stall) begin
                check("stall_valid", 64'(m_valid), 64'd1);
                check("stall_data", m_data, prev_data);
                check("stall_keep", 64'(m_keep), 64'(prev_keep));
                check("stall_last", 64'(m_last), 64'(prev_last));
            end
            if (m_valid && !m_ready) check("stall_sready", 64'(s_ready), 64'd0);
            if (m_valid && m_ready) begin
                o.data = m_data; o.keep = m_keep; o.last = m_last; o.user = m_user;
                obs_q.push_back(o);
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 64'(exp_q.size()), 64'd1);
                end else begin
                    e  = exp_q.pop_front();
                    mk = keep_mask(e.keep);
                    check("beat_data", m_data & mk, e.data & mk);
                    check("beat_keep", 64'(m_keep), 64'(e.keep));
                    check("beat_last", 64'(m_last), 64'(e.last));
                    check("beat_user", 64'(m_user), 64'(e.user));
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_keep  = m_keep;
            prev_last  = m_last;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          start_cyc;
        logic [63:0] icmp_pkt[$];

        repeat (3) @(posedge i_clk);
        #1;
        check("reset_data", m_data, 64'd0);
        check("reset_user", 64'(m_user), 64'd0);
        check("reset_keep", 64'(m_keep), 64'd0);
        check("reset_last", 64'(m_last), 64'd0);
        check("reset_valid", 64'(m_valid), 64'd0);
        check("reset_sready", 64'(s_ready), 64'd0);
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;

        // ICMP echo, 5 full beats, no back-pressure
        fill_pkt(5, 64'h0000_0000_0001_0002);
        icmp_pkt = pkt_q;
        obs_q.delete();
        first_valid_cyc = -1;
        start_cyc = cyc;
        send_pkt(16'd40, 3'b010, 8'd1, 13'd0, 16'h0001, 32'hC0A86402, 32'hC0A86401, 8'hFF, -1);
        drain();
        check("hdr0_latency", 64'(first_valid_cyc - start_cyc), 64'd4);
        check("icmp_nbeats", 64'(obs_q.size()), 64'd8);
        if (obs_q.size() == 8) begin
            check("icmp_b0", obs_q[0].data, 64'h4500003C00014000);
            check("icmp_b1", obs_q[1].data, 64'h4001F16BC0A86402);
            check("icmp_b2", obs_q[2].data, 64'hC0A8640100000000);
            check("icmp_b3_hi", 64'(obs_q[3].data[63:32]), 64'h00010002);
            check("icmp_last_keep", 64'(obs_q[7].keep), 64'hF0);
            check("icmp_user", 64'(obs_q[0].user), 64'h003C_C0A86401);
        end

        // Last beat with 7 bytes: extra TAIL beat
        fill_pkt(3, {$urandom, $urandom});
        obs_q.delete();
        send_pkt(16'd23, 3'b000, 8'd17, 13'd0, 16'h0042, 32'h0A000001, 32'h0A000002, 8'hFE, -1);
        drain();
        check("tail_nbeats", 64'(obs_q.size()), 64'd6);
        if (obs_q.size() == 6) begin
            check("tail_keep", 64'(obs_q[5].keep), 64'hE0);
            check("tail_prelast", 64'(obs_q[4].last), 64'd0);
        end

        // Single 4-byte payload beat
        fill_pkt(1, 64'hDEADBEEF_5A5A5A5A);
        obs_q.delete();
        send_pkt(16'd4, 3'b000, 8'd1, 13'd0, 16'h0007, 32'h01020304, 32'h05060708, 8'hF0, -1);
        drain();
        check("single_nbeats", 64'(obs_q.size()), 64'd3);
        if (obs_q.size() == 3) begin
            check("single_data", obs_q[2].data, 64'h05060708_DEADBEEF);
            check("single_keep", 64'(obs_q[2].keep), 64'hFF);
            check("single_last", 64'(obs_q[2].last), 64'd1);
            check("single_totlen", 64'(obs_q[2].user[47:32]), 64'd24);
        end

        // Random back-pressure on the same ICMP packet and a short-tail packet
        stall_en = 1'b1;
        pkt_q = icmp_pkt;
        send_pkt(16'd40, 3'b010, 8'd1, 13'd0, 16'h0001, 32'hC0A86402, 32'hC0A86401, 8'hFF, -1);
        drain();
        fill_pkt(2, {$urandom, $urandom});
        send_pkt(16'd10, 3'b001, 8'd6, 13'h0123, 16'hCAFE, 32'hAC100001, 32'hAC1000FE, 8'hC0, -1);
        drain();
        stall_en = 1'b0;
        @(posedge i_clk);
        #1;

        // Back-to-back packets, s_valid kept high across the boundary
        fill_pkt(2, {$urandom, $urandom});
        send_pkt(16'd16, 3'b000, 8'd17, 13'd0, 16'h1234, 32'hC0A80001, 32'hC0A80002, 8'hFF, -1);
        fill_pkt(3, {$urandom, $urandom});
        send_pkt(16'd21, 3'b010, 8'd17, 13'd0, 16'hBEEF, 32'hC0A80003, 32'hC0A80004, 8'hF8, -1);
        drain();

        // Reset during payload, then a fresh packet
        fill_pkt(4, {$urandom, $urandom});
        send_pkt(16'd32, 3'b000, 8'd1, 13'd0, 16'h0BAD, 32'h0A0A0A0A, 32'h0B0B0B0B, 8'hFF, 1);
        exp_q.delete();
        repeat (2) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        @(posedge i_clk);
        #1;
        pkt_q = icmp_pkt;
        obs_q.delete();
        send_pkt(16'd40, 3'b010, 8'd1, 13'd0, 16'h0002, 32'hC0A86402, 32'hC0A86401, 8'hFF, -1);
        drain();
        check("post_rst_nbeats", 64'(obs_q.size()), 64'd8);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ip_tx_builder.md
Name: ip_tx_builder

Overview:
- Sits directly downstream of the ICMP transmit generator and any other IP-payload source.
- Consumes a 64-bit AXI-Stream IP payload with per-packet sideband {len, flags, protocol, offset, ID}.
- Builds a 20-byte IPv4 header (no options) with computed header checksum and emits header plus realigned payload as a 64-bit stream toward the MAC framer.
- Payload is shifted 4 bytes because the header is 2.5 beats long.

Parameters:
P_TTL, 8'd64, TTL field inserted in every header
P_TOS, 8'd0, TOS/DSCP field

Ports:
i_clk  in  1  clock
i_rst_n  in  1  reset; asynchronous, active-low
i_src_ip  in  32  source address, sampled at packet start
i_dst_ip  in  32  destination address, sampled at packet start
s_axis_ip_data  in  64  payload; byte 0 in [63:56]
s_axis_ip_user  in  56  {16 payload len bytes, 3 flags, 8 protocol, 13 frag offset, 16 ID}; valid with first beat
s_axis_ip_keep  in  8  MSB-contiguous byte enable; only the last beat may be partial
s_axis_ip_last  in  1  end of payload
s_axis_ip_valid  in  1  upstream valid
s_axis_ip_ready  out  1  upstream ready
m_axis_mac_data  out  64  IPv4 packet; byte 0 in [63:56]
m_axis_mac_user  out  48  {16 total_len, 32 dst_ip}; constant for the packet
m_axis_mac_keep  out  8  MSB-contiguous byte enable
m_axis_mac_last  out  1  end of packet
m_axis_mac_valid  out  1  downstream valid
m_axis_mac_ready  in  1  downstream ready

Behaviour:
- Reset (i_rst_n low, async): every output register is 0 (data, user, keep, last, valid, s_ready); FSM goes to IDLE; checksum and residue registers are cleared.
- Reset mid-packet aborts the packet with no completion. The bench restarts upstream.
- Output is a single register stage. Once m_valid is high, data, keep, last and valid are held until m_ready is high.
- A new output beat loads only when the output stage is empty or the current beat is being taken: ld = !m_valid || m_ready.
- s_axis_ip_ready = (state==DATA) && ld.
- FSM states: IDLE, CSUM1, CSUM2, HDR0, HDR1, DATA, TAIL.
- IDLE:
  - On s_valid, capture user fields, src and dst IP. The beat is not consumed.
  - Compute total_len = len + 20 (16-bit wrap, no saturation).
  - Go to CSUM1.
- CSUM1: 20-bit sum of the nine 16-bit words: {4'h4,4'h5,P_TOS}, total_len, ID, {flags,offset}, {P_TTL,protocol}, src[31:16], src[15:0], dst[31:16], dst[15:0].
- CSUM2: fold the carry twice into 16 bits, then invert to form the checksum. Go to HDR0.
- HDR0 (when ld):
  - Output {8'h45, P_TOS, total_len, ID, flags, offset}, keep 8'hFF.
  - Set m_axis_mac_user = {total_len, dst}.
  - Go to HDR1.
- HDR1 (when ld):
  - Output {P_TTL, protocol, checksum, src}, keep 8'hFF.
  - Preload residue = dst. Go to DATA.
- DATA, per accepted input beat (valid && ready):
  - Output {residue, in[63:32]}; then residue <= in[31:0].
  - Non-last beat: keep 8'hFF.
  - Last beat with n = popcount(keep) ≤ 4: output keep = {4'hF, in_keep[7:4]}, last = 1, go to IDLE.
  - Last beat with n > 4: output keep 8'hFF, last = 0, go to TAIL.
- TAIL (when ld): output {residue, 32'h0}, keep = {in_keep_saved[3:0], 4'h0}, last = 1, go to IDLE.
- Latency: s_valid seen in IDLE at cycle N → HDR0 beat presented with m_valid high at N+3 when downstream is ready. The first payload beat is accepted no earlier than N+5.
- Back-to-back packets: IDLE is re-entered the cycle after the last beat loads. The next packet's user is sampled then, even if the previous last beat is still stalled.
- The payload length field is trusted. The header uses it even if the beat count disagrees; no error is flagged.
- Protocol is inserted unchanged (1 = ICMP, 17 = UDP).

Test Plan:
- ICMP echo, reset released; user {40, 3'b010, 1, 0, 16'h0001}, src C0A86402, dst C0A86401, 5 full beats, first beat 0000_0000_0001_0002, m_ready=1 → 8 beats: 4500003C00014000, 4001F16BC0A86402, C0A8640100000000, 00010002_xxxxxxxx …; last beat keep 8'hF0; user {16'h003C, C0A86401}.
- Last input beat with keep 8'hFE (n=7) → extra TAIL beat, keep 8'hE0, last only on TAIL.
- Single-beat payload, keep 8'hF0, len 4 → 3 output beats; third = {dst, 4 bytes}, keep 8'hFF, last=1; total_len 24.
- Random m_ready deassertion at 50% through header and payload → data/keep/last stable while valid && !ready; byte stream identical to the no-stall run; s_ready low during stalls.
- Two packets back-to-back with s_valid held high, different IDs → second HDR0 follows the first's last beat after 3 cycles; checksums independently correct against a reference model.
- Assert i_rst_n low during DATA → all outputs 0 immediately (async); after release, a fresh packet produces correct output.
